// File: rtl/cpu_defs_pkg.sv
// Purpose: shared definitions for the load/store unit (FSM states, lane helpers).
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package cpu_defs;

    typedef enum logic [1:0] {
        LSU_IDLE      = 2'd0,
        LSU_LOAD_REQ  = 2'd1,
        LSU_LOAD_WAIT = 2'd2
    } lsu_state_t;

    // Lane geometry for the default 16-bit datapath.
    localparam int DEFAULT_BITS = 16;
    localparam int LANES        = DEFAULT_BITS / 8;
    localparam int LANE_BITS    = $clog2(LANES);

    // Byte lanes in a BITS-wide word.
    function automatic int lanes_of(input int bits);
        return bits / 8;
    endfunction

    // Width of the lane index; never below 1 so part-selects stay legal.
    function automatic int lane_bits_of(input int bits);
        return ((bits / 8) > 1) ? $clog2(bits / 8) : 1;
    endfunction

endpackage

// File: rtl/cpu_store_fifo.sv
// Purpose: generic synchronous FIFO buffering store entries ahead of the memory bus.
// Latency: a pushed entry is visible on pop_data the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty; caller watches full/empty.
// Ports: CLK, RST (async, active-high), push/push_data, pop/pop_data (head, combinational),
//        full, empty, count.
module cpu_store_fifo
    import cpu_defs::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int CNT_BITS = PTR_BITS + 1;

    logic [WIDTH-1:0]    storage [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign full     = (count == CNT_BITS'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = storage[rd_ptr];

    // Payload storage carries no reset; only pointers and count define validity.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            storage[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_BITS'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_BITS'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_BITS'(1);
                2'b01:   count <= count - CNT_BITS'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cpu_load_store_unit.sv
// Purpose: sequential load/store unit between execute and the memory bus (store buffer + load FSM).
// Latency: stores reach the bus the cycle after acceptance; load result 1 cycle after mem_rvalid.
// Backpressure: req_ready low when the store buffer is full, a load is in flight, or a load waits on stores.
// Ports: CLK, RST; req_* from execute (valid/ready); mem_* request channel (valid/ready) and
//        mem_rvalid/mem_rdata response; wb_* registered load writeback; align_error pulse; idle.
module cpu_load_store_unit
    import cpu_defs::*;
#(
    parameter int BITS          = 16,
    parameter int ADDRESS_BITS  = 16,
    parameter int REGISTER_BITS = 4,
    parameter int STORE_DEPTH   = 4
) (
    input  logic                                          CLK,
    input  logic                                          RST,
    input  logic                                          req_valid,
    output logic                                          req_ready,
    input  logic                                          req_store,
    input  logic                                          req_byte,
    input  logic                                          req_sx,
    input  logic [ADDRESS_BITS-1:0]                       req_address,
    input  logic [BITS-1:0]                               req_data,
    input  logic [REGISTER_BITS-1:0]                      req_dest,
    output logic                                          mem_valid,
    input  logic                                          mem_ready,
    output logic                                          mem_wr,
    output logic [ADDRESS_BITS-lane_bits_of(BITS)-1:0]    mem_addr,
    output logic [BITS-1:0]                               mem_wdata,
    output logic [BITS/8-1:0]                             mem_wr_mask,
    input  logic                                          mem_rvalid,
    input  logic [BITS-1:0]                               mem_rdata,
    output logic                                          wb_valid,
    output logic [REGISTER_BITS-1:0]                      wb_dest,
    output logic [BITS-1:0]                               wb_data,
    output logic                                          align_error,
    output logic                                          idle
);

    localparam int LANE_CNT   = lanes_of(BITS);
    localparam int LANE_W     = lane_bits_of(BITS);
    localparam int WADDR_BITS = ADDRESS_BITS - LANE_W;
    localparam int CNT_BITS   = $clog2(STORE_DEPTH) + 1;

    typedef struct packed {
        logic [WADDR_BITS-1:0] addr;
        logic [BITS-1:0]       wdata;
        logic [LANE_CNT-1:0]   mask;
    } store_entry_t;

    localparam int ENTRY_BITS = $bits(store_entry_t);

    lsu_state_t              state;
    logic [LANE_W-1:0]       req_lane;
    logic [WADDR_BITS-1:0]   req_waddr;
    logic                    misaligned;
    logic                    req_fire;
    logic                    store_fire;
    logic                    load_fire;
    logic                    drain_fire;

    store_entry_t            new_entry;
    store_entry_t            head_entry;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CNT_BITS-1:0]     fifo_count;

    logic [WADDR_BITS-1:0]   ld_waddr;
    logic [LANE_W-1:0]       ld_lane;
    logic                    ld_byte;
    logic                    ld_sx;
    logic [REGISTER_BITS-1:0] ld_dest;
    logic [7:0]              lane_byte;
    logic [BITS-1:0]         load_result;

    assign req_lane   = req_address[LANE_W-1:0];
    assign req_waddr  = req_address[ADDRESS_BITS-1:LANE_W];
    assign misaligned = !req_byte && (req_lane != '0);

    // Loads wait for an empty store buffer, giving program order without forwarding.
    // A full buffer stalls stores even when a drain completes this cycle.
    assign req_ready  = (state == LSU_IDLE) && (req_store ? !fifo_full : fifo_empty);
    assign req_fire   = req_valid && req_ready;
    assign store_fire = req_fire && req_store && !misaligned;
    assign load_fire  = req_fire && !req_store && !misaligned;
    assign drain_fire = (state == LSU_IDLE) && !fifo_empty && mem_ready;

    assign idle = (fifo_count == '0) && (state == LSU_IDLE);

    // Store entry: byte stores land in their lane with a one-hot mask.
    always_comb begin
        new_entry      = '0;
        new_entry.addr = req_waddr;
        if (req_byte) begin
            for (int i = 0; i < LANE_CNT; i++) begin
                if (req_lane == LANE_W'(i)) begin
                    new_entry.wdata[8*i +: 8] = req_data[7:0];
                    new_entry.mask[i]         = 1'b1;
                end
            end
        end else begin
            new_entry.wdata = req_data;
            new_entry.mask  = '1;
        end
    end

    cpu_store_fifo #(
        .WIDTH (ENTRY_BITS),
        .DEPTH (STORE_DEPTH)
    ) u_store_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (store_fire),
        .push_data (new_entry),
        .pop       (drain_fire),
        .pop_data  (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Bus outputs depend only on registered state, so they hold until mem_ready:
    // the FIFO head cannot change without a pop, and load fields are latched.
    always_comb begin
        mem_valid   = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_wr_mask = '1;
        if (state == LSU_LOAD_REQ) begin
            mem_valid = 1'b1;
            mem_addr  = ld_waddr;
        end else if ((state == LSU_IDLE) && !fifo_empty) begin
            mem_valid   = 1'b1;
            mem_wr      = 1'b1;
            mem_addr    = head_entry.addr;
            mem_wdata   = head_entry.wdata;
            mem_wr_mask = head_entry.mask;
        end
    end

    // Load data alignment and extension.
    always_comb begin
        lane_byte = '0;
        for (int i = 0; i < LANE_CNT; i++) begin
            if (ld_lane == LANE_W'(i)) begin
                lane_byte = mem_rdata[8*i +: 8];
            end
        end
        if (ld_byte) begin
            load_result = {{(BITS-8){ld_sx & lane_byte[7]}}, lane_byte};
        end else begin
            load_result = mem_rdata;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= LSU_IDLE;
            ld_waddr    <= '0;
            ld_lane     <= '0;
            ld_byte     <= 1'b0;
            ld_sx       <= 1'b0;
            ld_dest     <= '0;
            wb_valid    <= 1'b0;
            wb_dest     <= '0;
            wb_data     <= '0;
            align_error <= 1'b0;
        end else begin
            align_error <= req_fire && misaligned;
            wb_valid    <= 1'b0;
            case (state)
                LSU_IDLE: begin
                    if (load_fire) begin
                        ld_waddr <= req_waddr;
                        ld_lane  <= req_lane;
                        ld_byte  <= req_byte;
                        ld_sx    <= req_sx;
                        ld_dest  <= req_dest;
                        state    <= LSU_LOAD_REQ;
                    end
                end
                LSU_LOAD_REQ: begin
                    if (mem_ready) begin
                        state <= LSU_LOAD_WAIT;
                    end
                end
                LSU_LOAD_WAIT: begin
                    // Responses are only honoured here; stray rvalid elsewhere is dropped.
                    if (mem_rvalid) begin
                        wb_valid <= 1'b1;
                        wb_dest  <= ld_dest;
                        wb_data  <= load_result;
                        state    <= LSU_IDLE;
                    end
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: doc/cpu_load_store_unit.md
Name: cpu_load_store_unit

Overview:
- Parametrised successor to the execute stage's combinational load/store decode: a sequential load/store unit between execute and the memory bus.
- Buffers stores in a STORE_DEPTH FIFO. Issues loads and stores over a valid/ready memory handshake. Stalls execute through req_ready.
- Aligns, masks and sign/zero-extends byte and word accesses for any BITS that is a multiple of 8, and returns load data on a registered writeback port.

Parameters:
- BITS, 16: data word width; multiple of 8, at least 16.
- ADDRESS_BITS, 16: byte address width.
- REGISTER_BITS, 4: destination register index width.
- STORE_DEPTH, 4: store buffer entries; power of two, at least 2.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset: asynchronous, active-high. Clears all state.
- req_valid  in  1  execute presents an access.
- req_ready  out  1  unit accepts it this cycle; execute stalls when low.
- req_store  in  1  1 = store, 0 = load.
- req_byte  in  1  1 = byte access, 0 = full word.
- req_sx  in  1  sign-extend byte load.
- req_address  in  ADDRESS_BITS  byte address (regB + imm).
- req_data  in  BITS  store data (regA); the byte is in [7:0].
- req_dest  in  REGISTER_BITS  load destination register.
- mem_valid  out  1  memory request valid.
- mem_ready  in  1  memory accepts request.
- mem_wr  out  1  1 = write.
- mem_addr  out  ADDRESS_BITS-log2(BITS/8)  word address.
- mem_wdata  out  BITS  write data.
- mem_wr_mask  out  BITS/8  byte-lane write enables.
- mem_rvalid  in  1  read data valid, one-cycle pulse.
- mem_rdata  in  BITS  read data.
- wb_valid  out  1  load result valid, one-cycle pulse.
- wb_dest  out  REGISTER_BITS  destination register.
- wb_data  out  BITS  aligned and extended load data.
- align_error  out  1  one-cycle pulse: misaligned word access was dropped.
- idle  out  1  store buffer empty and no load in flight. Gates halt/sleep.

Behaviour:
- Reset values: req_ready=1, mem_valid=0, mem_wr=0, mem_addr=0, mem_wdata=0, mem_wr_mask=all ones, wb_valid=0, wb_dest=0, wb_data=0, align_error=0, idle=1. FIFO pointers and count are cleared.
- Lane index: lane = req_address[log2(BITS/8)-1:0]. Lane i occupies bits [8i+7:8i].
- mem_addr = req_address >> log2(BITS/8).
- Byte store:
  - mask = one-hot at lane.
  - wdata = req_data[7:0] placed at lane; all other lanes 0.
- Word store: mask all ones; wdata = req_data.
- Misaligned word access (lane != 0, load or store):
  - Accepted when req_ready is high.
  - Not enqueued and not issued.
  - align_error pulses the next cycle.
- Store acceptance: req_ready is high for a store when the FIFO is not full and the FSM is IDLE.
  - Entry = {mem_addr, wdata, mask}.
  - No full-bypass: when count==STORE_DEPTH, req_ready=0, even if a drain completes that cycle.
- Load acceptance: req_ready is high for a load only when the FIFO is empty and the FSM is IDLE. This gives strict program order and needs no forwarding.
- FSM states and transitions:
  - IDLE -> LOAD_REQ when a load handshakes.
  - LOAD_REQ -> LOAD_WAIT on mem_valid & mem_ready.
  - LOAD_WAIT -> IDLE on mem_rvalid.
- Load request latching: address, lane, byte, sx and dest are registered at acceptance.
- mem_rvalid in the same cycle as the handshake is not permitted (minimum read latency is 1 cycle).
- Store drain:
  - In IDLE with the FIFO non-empty, mem_valid=1 and mem_wr=1, presenting the head entry.
  - The head is popped on mem_ready. Back-to-back drains are allowed, one per cycle.
  - Enqueue and pop in the same cycle leave count unchanged.
- Handshake: once mem_valid rises, mem_valid and all mem_* outputs hold stable until mem_ready.
- Load result: registered, wb_valid pulses 1 cycle after mem_rvalid.
  - Byte load: lane byte selected, then zero- or sign-extended to BITS.
  - Word load: wb_data = mem_rdata.
- idle = (count==0) & (state==IDLE). Combinational.
- mem_rvalid outside LOAD_WAIT is ignored, including a stale response after reset.
- RST mid-transaction: immediate return to reset values; buffered stores are discarded.

Decomposition:
- Shared package (cpu_defs): state encodings LSU_IDLE, LSU_LOAD_REQ, LSU_LOAD_WAIT; localparam LANES = BITS/8 and LANE_BITS = log2(LANES).
- One sub-module: cpu_store_fifo, a parametrised synchronous FIFO with WIDTH and DEPTH parameters, push/pop/full/empty/count, and asynchronous active-high RST.

Test Plan (BITS=16, STORE_DEPTH=4):
- Byte store, address 0x0101, data 0x00AB -> mem_addr=0x0080, wdata=0xAB00, mask=2'b10, mem_wr=1; after mem_ready, idle=1.
- Sign-extended byte load, address 0x0011, mem_rdata=0x80FF with 3-cycle rvalid latency -> wb_valid pulses 1 cycle after rvalid, wb_data=0xFF80. With req_sx=0 -> wb_data=0x0080.
- Five word stores with mem_ready held low -> req_ready drops after the fourth. Raise mem_ready -> four writes drain in order, one per cycle; the fifth is accepted when count<4.
- Load issued behind two pending stores -> req_ready=0 until both drain. Load handshake follows the second write; the read address equals the load address >> 1.
- Word store to address 0x0003 -> not issued on the bus, align_error pulses once, count unchanged.
- Assert RST while in LOAD_WAIT with 2 stores queued, then pulse mem_rvalid -> no wb_valid, idle=1, mem_valid=0.
